// File: rtl/fft_peak_detect_if.sv
// Bin-stream and result-port signal bundle for fft_peak_detect.
// Handshake semantics: a bin is transferred on a rising edge where in_push=1
// and in_stall=0; a result is transferred on the edge where out_push_F=1,
// which the block only raises when out_stall was 0 in the preceding cycle.
interface fft_peak_detect_if;
    logic               in_push;
    logic signed [15:0] in_real;
    logic signed [15:0] in_imag;
    logic               in_stall;
    logic               out_push_F;
    logic        [3:0]  out_bin_F;
    logic        [31:0] out_peak_F;
    logic        [35:0] out_energy_F;
    logic               out_stall;
    logic               dbg_hold;   // output FSM state: 1 = result held

    modport slave (
        input  in_push, in_real, in_imag, out_stall,
        output in_stall, out_push_F, out_bin_F, out_peak_F, out_energy_F, dbg_hold
    );

    modport master (
        output in_push, in_real, in_imag, out_stall,
        input  in_stall, out_push_F, out_bin_F, out_peak_F, out_energy_F, dbg_hold
    );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak bin / peak power / total energy of a 16-bin FFT stream.
// Three-stage pipeline (register, square, accumulate) feeding a one-deep
// result holder whose occupancy back-pressures the FFT core.
module fft_peak_detect #(
    parameter bit SKIP_DC = 1'b0
) (
    input logic            clk,
    input logic            reset,
    fft_peak_detect_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_next;
    logic               capture, deliver;
    logic               accept;
    logic        [3:0]  bin_cnt;

    logic               s0_valid, s0_last;
    logic        [3:0]  s0_bin;
    logic signed [15:0] s0_real, s0_imag;
    logic signed [31:0] sq_real, sq_imag;
    logic        [31:0] pow;

    logic               s1_valid, s1_last;
    logic        [3:0]  s1_bin;
    logic        [31:0] s1_pow;

    logic        [31:0] run_peak, peak_next;
    logic        [3:0]  run_bin, bin_next;
    logic        [35:0] run_energy, energy_next;

    logic        [31:0] res_peak;
    logic        [3:0]  res_bin;
    logic        [35:0] res_energy;

    assign accept  = bus.in_push & ~bus.in_stall;
    assign sq_real = s0_real * s0_real;
    assign sq_imag = s0_imag * s0_imag;
    // Each square is at most 2^30, so the unsigned sum fits in 32 bits.
    assign pow     = $unsigned(sq_real) + $unsigned(sq_imag);
    assign bus.dbg_hold = (state == HOLD);

    // Bin counter: counts accepted samples, value equals the bin index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      bin_cnt <= 4'd0;
        else if (accept) bin_cnt <= bin_cnt + 4'd1;
    end

    // S0: capture the accepted sample with its bin index and last tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s0_bin   <= 4'd0;
            s0_real  <= '0;
            s0_imag  <= '0;
        end else begin
            s0_valid <= accept;
            s0_last  <= accept && (bin_cnt == 4'd15);
            if (accept) begin
                s0_bin  <= bin_cnt;
                s0_real <= bus.in_real;
                s0_imag <= bus.in_imag;
            end
        end
    end

    // S1: register the bin power.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= 4'd0;
            s1_pow   <= '0;
        end else begin
            s1_valid <= s0_valid;
            s1_last  <= s0_valid && s0_last;
            if (s0_valid) begin
                s1_bin <= s0_bin;
                s1_pow <= pow;
            end
        end
    end

    // S2 combinational update: bin 0 reloads, later bins accumulate; strict > keeps the lower bin on ties.
    always_comb begin
        peak_next   = run_peak;
        bin_next    = run_bin;
        energy_next = run_energy;
        if (s1_bin == 4'd0) begin
            energy_next = {4'd0, s1_pow};
            peak_next   = SKIP_DC ? 32'd0 : s1_pow;
            bin_next    = 4'd0;
        end else begin
            energy_next = run_energy + {4'd0, s1_pow};
            if (s1_pow > run_peak) begin
                peak_next = s1_pow;
                bin_next  = s1_bin;
            end
        end
    end

    // S2 register: running peak and energy of the current frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_peak   <= '0;
            run_bin    <= 4'd0;
            run_energy <= '0;
        end else if (s1_valid) begin
            run_peak   <= peak_next;
            run_bin    <= bin_next;
            run_energy <= energy_next;
        end
    end

    // Output FSM next state: IDLE captures a finished frame, HOLD waits for the consumer.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        deliver    = 1'b0;
        case (state)
            IDLE: if (s1_valid && s1_last) begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: if (!bus.out_stall) begin
                deliver    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output FSM state register; in_stall mirrors the next occupancy of the holder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.in_stall <= 1'b0;
        end else begin
            state        <= state_next;
            bus.in_stall <= (state_next == HOLD);
        end
    end

    // Result holder: snapshot of the frame's final peak and energy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_peak   <= '0;
            res_bin    <= 4'd0;
            res_energy <= '0;
        end else if (capture) begin
            res_peak   <= peak_next;
            res_bin    <= bin_next;
            res_energy <= energy_next;
        end
    end

    // Result port: one-cycle strobe, data buses hold until the next delivery.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_push_F   <= 1'b0;
            bus.out_bin_F    <= 4'd0;
            bus.out_peak_F   <= '0;
            bus.out_energy_F <= '0;
        end else begin
            bus.out_push_F <= deliver;
            if (deliver) begin
                bus.out_bin_F    <= res_bin;
                bus.out_peak_F   <= res_peak;
                bus.out_energy_F <= res_energy;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: two instances (SKIP_DC=0 and 1)
// share one stimulus stream; a frame-level reference model fills per-instance
// expected queues that a monitor drains on every result strobe.
module tb_fft_peak_detect;
    logic clk;
    logic reset;
    fft_peak_detect_if bus();
    fft_peak_detect_if bus_dc();

    fft_peak_detect #(.SKIP_DC(1'b0)) dut    (.clk(clk), .reset(reset), .bus(bus));
    fft_peak_detect #(.SKIP_DC(1'b1)) dut_dc (.clk(clk), .reset(reset), .bus(bus_dc));

    assign bus_dc.in_push   = bus.in_push;
    assign bus_dc.in_real   = bus.in_real;
    assign bus_dc.in_imag   = bus.in_imag;
    assign bus_dc.out_stall = bus.out_stall;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    logic [71:0] exp_q[$];
    logic [71:0] exp_q_dc[$];
    logic [71:0] last_got, last_got_dc;

    logic signed [15:0] frm_re[16];
    logic signed [15:0] frm_im[16];
    int frm_n = 0;

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Frame reference: power of every bin, energy = sum, peak = first maximum.
    function automatic logic [71:0] model(input bit skip);
        longint pw[16];
        longint en, bp;
        int bb;
        en = 0;
        for (int i = 0; i < 16; i++) begin
            pw[i] = longint'(frm_re[i]) * longint'(frm_re[i])
                  + longint'(frm_im[i]) * longint'(frm_im[i]);
            en += pw[i];
        end
        bb = 0;
        bp = skip ? 64'sd0 : pw[0];
        for (int i = 1; i < 16; i++)
            if (pw[i] > bp) begin
                bp = pw[i];
                bb = i;
            end
        return {4'(bb), 32'(bp), 36'(en)};
    endfunction

    // Monitor: every strobe is checked against the head of the expected queue.
    always @(posedge clk) begin
        #1;
        if (bus.out_push_F === 1'b1) begin
            n_strobe++;
            last_got = {bus.out_bin_F, bus.out_peak_F, bus.out_energy_F};
            if (exp_q.size() == 0) chk("unexpected_strobe", 72'd1, 72'd0);
            else chk("model_skip0", last_got, exp_q.pop_front());
        end
        if (bus_dc.out_push_F === 1'b1) begin
            last_got_dc = {bus_dc.out_bin_F, bus_dc.out_peak_F, bus_dc.out_energy_F};
            if (exp_q_dc.size() == 0) chk("unexpected_strobe_dc", 72'd1, 72'd0);
            else chk("model_skip1", last_got_dc, exp_q_dc.pop_front());
        end
    end

    // ---------------- driver ----------------
    // Holds the sample until an edge where in_stall was low; records it in the model.
    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        bus.in_push = 1'b1;
        bus.in_real = re;
        bus.in_imag = im;
        while (!acc && guard < 50) begin
            acc = !bus.in_stall;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_push = 1'b0;
        if (!acc) chk("send_timeout", 72'd1, 72'd0);
        else begin
            frm_re[frm_n] = re;
            frm_im[frm_n] = im;
            frm_n++;
            if (frm_n == 16) begin
                exp_q.push_back(model(1'b0));
                exp_q_dc.push_back(model(1'b1));
                frm_n = 0;
            end
        end
    endtask

    task automatic wait_strobe(input int n0, input string nm);
        int guard;
        guard = 0;
        while (n_strobe == n0 && guard < 12) begin
            @(negedge clk);
            guard++;
        end
        chk(nm, 72'(n_strobe - n0), 72'd1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_skip0"}, {bus.in_stall, bus.out_push_F, bus.out_bin_F,
                             bus.out_peak_F, bus.out_energy_F}, 72'd0);
        chk({nm, "_skip1"}, {bus_dc.in_stall, bus_dc.out_push_F, bus_dc.out_bin_F,
                             bus_dc.out_peak_F, bus_dc.out_energy_F}, 72'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit                 ramp;
        int                 b1;
        logic signed [15:0] r1, i1;
        int                 b2;
        logic signed [15:0] r2, i2;
        logic [71:0]        exp0;
        logic [71:0]        exp1;
    } vec_t;

    vec_t vec[7];

    initial begin
        int n0;
        logic signed [15:0] re, im;

        vec[0] = '{1'b0, 0, 16'sd1000, 16'sd0, 5, 16'sd10, 16'sd0,
                   {4'd0, 32'd1000000, 36'd1000100}, {4'd5, 32'd100, 36'd1000100}};
        vec[1] = '{1'b1, 0, 16'sd0, 16'sd0, 0, 16'sd0, 16'sd0,
                   {4'd15, 32'd225, 36'd1240}, {4'd15, 32'd225, 36'd1240}};
        vec[2] = '{1'b0, 3, -16'sd32768, -16'sd32768, 9, -16'sd32768, -16'sd32768,
                   {4'd3, 32'h8000_0000, 36'h1_0000_0000}, {4'd3, 32'h8000_0000, 36'h1_0000_0000}};
        vec[3] = '{1'b0, 0, 16'sd0, 16'sd0, 0, 16'sd0, 16'sd0,
                   72'd0, 72'd0};
        vec[4] = '{1'b0, 7, 16'sd3, 16'sd4, 12, -16'sd5, 16'sd0,
                   {4'd7, 32'd25, 36'd50}, {4'd7, 32'd25, 36'd50}};
        vec[5] = '{1'b0, 15, -16'sd1, -16'sd1, 15, -16'sd1, -16'sd1,
                   {4'd15, 32'd2, 36'd2}, {4'd15, 32'd2, 36'd2}};
        vec[6] = '{1'b0, 0, 16'sd0, 16'sd7, 4, 16'sd7, 16'sd0,
                   {4'd0, 32'd49, 36'd98}, {4'd4, 32'd49, 36'd98}};

        // Reset state
        reset = 1'b0;
        bus.in_push = 1'b0;
        bus.in_real = '0;
        bus.in_imag = '0;
        bus.out_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame with exact latency and stall timing
        for (int n = 0; n < 16; n++) send(16'(n), 16'sd0);
        chk("ramp_k_push", 72'(bus.out_push_F), 72'd0);
        @(posedge clk); #1;
        chk("ramp_k1", {bus.out_push_F, bus.in_stall}, 72'd0);
        @(posedge clk); #1;
        chk("ramp_k2", {bus.out_push_F, bus.in_stall}, 72'b01);
        @(posedge clk); #1;
        chk("ramp_k3", {bus.out_push_F, bus.in_stall}, 72'b10);
        chk("ramp_k3_data", {bus.out_bin_F, bus.out_peak_F, bus.out_energy_F},
            {4'd15, 32'd225, 36'd1240});
        @(posedge clk); #1;
        chk("ramp_k4", {bus.out_push_F, bus.out_peak_F}, {1'b0, 32'd225});

        // Result stall: 20 cycles of held result with dropped pushes
        bus.out_stall = 1'b1;
        for (int n = 0; n < 16; n++) send(16'(n * 3), -16'(n));
        repeat (2) begin @(posedge clk); #1; end
        for (int c = 0; c < 20; c++) begin
            bus.in_push = 1'b1;
            bus.in_real = 16'($urandom_range(0, 65535));
            bus.in_imag = 16'($urandom_range(0, 65535));
            @(posedge clk); #1;
            chk("stall_hold", {bus.in_stall, bus.out_push_F, bus_dc.out_push_F}, 72'b100);
        end
        bus.in_push = 1'b0;
        bus.out_stall = 1'b0;
        @(posedge clk); #1;
        chk("stall_release", {bus.out_push_F, bus.in_stall}, 72'b10);
        @(posedge clk); #1;
        chk("stall_single_strobe", 72'(bus.out_push_F), 72'd0);

        // Table-driven frames (first one also proves the post-stall frame starts at bin 0)
        for (int v = 0; v < 7; v++) begin
            n0 = n_strobe;
            for (int i = 0; i < 16; i++) begin
                if (vec[v].ramp) begin re = 16'(i); im = 16'sd0; end
                else if (i == vec[v].b1) begin re = vec[v].r1; im = vec[v].i1; end
                else if (i == vec[v].b2) begin re = vec[v].r2; im = vec[v].i2; end
                else begin re = 16'sd0; im = 16'sd0; end
                send(re, im);
            end
            wait_strobe(n0, $sformatf("vec%0d_strobe", v));
            chk($sformatf("vec%0d_skip0", v), last_got, vec[v].exp0);
            chk($sformatf("vec%0d_skip1", v), last_got_dc, vec[v].exp1);
        end

        // Back-to-back random frames
        n0 = n_strobe;
        for (int n = 0; n < 64; n++)
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        repeat (8) @(negedge clk);
        chk("b2b_strobes", 72'(n_strobe - n0), 72'd4);
        chk("b2b_queue_empty", 72'(exp_q.size() + exp_q_dc.size()), 72'd0);

        // Mid-frame reset after 7 samples
        for (int n = 0; n < 7; n++)
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        #3;
        reset = 1'b0;
        #1;
        chk_outputs_zero("midreset_outputs");
        frm_n = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n0 = n_strobe;
        for (int n = 0; n < 16; n++)
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        wait_strobe(n0, "midreset_strobe");
        repeat (4) @(negedge clk);
        chk("final_queue_empty", 72'(exp_q.size() + exp_q_dc.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
